// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes
// 11-bit frames (start, 8 data LSB first, odd parity, stop), strips the
// E0/F0 scan-code set 2 prefixes and strobes out one key event per make
// or break code. Frame faults and mid-frame stalls raise FrameError.
module ps2_keyboard_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] Keycode,
    output logic       Extended,
    output logic       Released,
    output logic       KeyValid,
    output logic       FrameError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic [1:0]    state;
    logic [7:0]    shreg;
    logic [2:0]    bitcnt;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          brk_pend, ext_pend;

    logic fall, dat, frame_ok, discard;

    assign fall     = clk_prev & ~clk_s2;
    assign dat      = dat_s2;
    // Stop bit must be 1 and data+parity must have odd weight.
    assign frame_ok = dat & (^shreg ^ par_bit);
    assign discard  = (shreg == 8'h00) || (shreg == 8'hAA) || (shreg == 8'hEE) ||
                      (shreg == 8'hFA) || (shreg == 8'hFE) || (shreg == 8'hFF);

    // Two-flop synchronisers plus a delayed copy of the clock for edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= PS2_CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= PS2_DAT;
            dat_s2   <= dat_s1;
        end
    end

    // Frame FSM, timeout watchdog, prefix tracking and registered key outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
            Keycode    <= '0;
            Extended   <= 1'b0;
            Released   <= 1'b0;
            KeyValid   <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            KeyValid   <= 1'b0;
            FrameError <= 1'b0;
            if (state != IDLE && tcnt == TMAX) begin
                // Stalled mid-frame: abandon it and forget any prefixes.
                state      <= IDLE;
                tcnt       <= '0;
                FrameError <= 1'b1;
                brk_pend   <= 1'b0;
                ext_pend   <= 1'b0;
            end else begin
                if (fall || state == IDLE)
                    tcnt <= '0;
                else if (tcnt != TMAX)
                    tcnt <= tcnt + TW'(1);

                if (fall) begin
                    case (state)
                        IDLE: begin
                            if (!dat) begin
                                state  <= DATA;
                                bitcnt <= '0;
                            end else begin
                                FrameError <= 1'b1;
                            end
                        end
                        DATA: begin
                            shreg  <= {dat, shreg[7:1]};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7)
                                state <= PARITY;
                        end
                        PARITY: begin
                            par_bit <= dat;
                            state   <= STOP;
                        end
                        default: begin
                            state <= IDLE;
                            if (!frame_ok) begin
                                FrameError <= 1'b1;
                                brk_pend   <= 1'b0;
                                ext_pend   <= 1'b0;
                            end else if (shreg == 8'hF0) begin
                                brk_pend <= 1'b1;
                            end else if (shreg == 8'hE0) begin
                                ext_pend <= 1'b1;
                            end else if (discard) begin
                                brk_pend <= 1'b0;
                                ext_pend <= 1'b0;
                            end else begin
                                Keycode  <= shreg;
                                Released <= brk_pend;
                                Extended <= ext_pend;
                                KeyValid <= 1'b1;
                                brk_pend <= 1'b0;
                                ext_pend <= 1'b0;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000; Clk cycles allowed between PS/2 clock falling edges inside a frame before the frame is aborted.
REQ-002 Clk  input  1  system clock; all state is sampled on the rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 PS2_CLK  input  1  raw PS/2 clock from the keyboard; asynchronous to Clk.
REQ-005 PS2_DAT  input  1  raw PS/2 data from the keyboard; asynchronous to Clk.
REQ-006 Keycode  output  8  last accepted scan-code set 2 key byte (prefixes stripped); this is the keycode consumed by the ASCII mapping stage.
REQ-007 Extended  output  1  high when Keycode was preceded by an E0 prefix.
REQ-008 Released  output  1  high when Keycode was preceded by an F0 prefix (break code).
REQ-009 KeyValid  output  1  one-Clk strobe; Keycode, Extended and Released are new this cycle.
REQ-010 FrameError  output  1  one-Clk strobe on a parity, start, stop or timeout error.

Function
REQ-011 PS2_CLK and PS2_DAT shall each pass through a 2-flop synchronizer; a falling edge is synced-clock 1 in the previous cycle and 0 in the current cycle.
REQ-012 Frame format: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1); all bits are sampled from synced PS2_DAT on the detected falling edge.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: on an edge with data 0 -> DATA with the bit counter cleared; on an edge with data 1 -> FrameError strobe and remain in IDLE.
REQ-015 DATA: each edge shifts one bit into the MSB of the shift register (right shift); after the 8th edge -> PARITY.
REQ-016 PARITY: on the edge, capture the bit -> STOP.
REQ-017 STOP: on the edge, the frame is good only if stop=1 and XOR(8 data bits, parity)=1; the FSM then returns to IDLE.
REQ-018 Good frame byte handling, resolved on the cycle after the stop edge:
  - 0xF0: set the break-pending flag; no KeyValid.
  - 0xE0: set the extended-pending flag; no KeyValid.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF: discard and clear both pending flags; no KeyValid.
  - any other byte: Keycode <= byte, Released <= break-pending, Extended <= extended-pending, KeyValid=1 for exactly one cycle, then clear both pending flags.
REQ-019 Latency: KeyValid shall assert exactly 1 Clk after the cycle in which the stop-bit falling edge is detected.
REQ-020 Keycode, Extended and Released shall hold their values until the next KeyValid.
REQ-021 Bad frame: FrameError=1 for one cycle (same timing as KeyValid); clear both pending flags; Keycode, Extended and Released unchanged; return to IDLE.
REQ-022 Timeout counter:
  - cleared on every detected edge and whenever the FSM is in IDLE;
  - increments otherwise, saturating at TIMEOUT_CYCLES;
  - on reaching TIMEOUT_CYCLES outside IDLE: -> IDLE, FrameError strobe, both pending flags cleared.
REQ-023 KeyValid and FrameError shall never assert in the same cycle, and neither shall assert in consecutive cycles from the same frame.
REQ-024 The prefix sequence E0 F0 xx shall yield Extended=1 and Released=1; the order F0 E0 xx shall yield the same result.
REQ-025 The block is receive-only; PS2_CLK and PS2_DAT are never driven.

Reset
REQ-026 On Reset_n=0, asynchronously:
  - FSM -> IDLE;
  - synchronizer flops -> 1;
  - shift register, bit counter and timeout counter -> 0;
  - both pending flags -> 0;
  - Keycode=0x00, Extended=0, Released=0, KeyValid=0, FrameError=0.
REQ-027 Reset asserted mid-frame discards the partial frame; after release, the next start bit begins a fresh frame with no error strobe.

Verification
REQ-028 Frame 0x1C with parity 0 -> one KeyValid; Keycode=0x1C, Extended=0, Released=0, 1 Clk after the stop edge.
REQ-029 Frames F0 then 1C -> no strobe after F0; after 1C, KeyValid with Keycode=0x1C, Released=1, Extended=0.
REQ-030 Frames E0, F0, 75 -> a single KeyValid with Keycode=0x75, Extended=1, Released=1; a following frame 16 -> Keycode=0x16, Extended=0, Released=0.
REQ-031 Frame 0x5A with a flipped parity bit -> FrameError strobe; no KeyValid; Keycode keeps its prior value.
REQ-032 Start plus 4 data bits, then PS2_CLK held high for TIMEOUT_CYCLES -> FrameError strobe and FSM in IDLE; a following frame 0x29 -> Keycode=0x29.
REQ-033 Reset_n pulsed low after 6 bits of a frame -> all outputs 0; a following full frame 0x45 -> Keycode=0x45 with no FrameError.
